spi_txn_arbiter: RTL

// - Shares one 8-bit SPI master between N requesters (one slave device per requester).
// - Round-robin arbitration; per-device active-low chip selects; CS setup and gap timing.
// - Launches the master with a start pulse and waits for its done pulse.
// - A timeout aborts a transaction if the master never reports done.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_txn_arbiter_rr_pick.sv | 28 ++
 rtl/spi_txn_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: arbiter/master state encoding and default timing.
// Also used by the SPI master, so keep the encoding stable.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_GAP_CYC  = 4;
    localparam int DEF_TIMEOUT  = 128;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Rotate right by ptr, isolate lowest set bit, rotate back left.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] back;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;

    // rotate so ptr lands at bit 0, pick lowest, rotate back
    always_comb begin
        dbl    = {req, req} >> ptr;
        rot    = dbl[N-1:0];
        low    = rot & (~rot + N'(1));
        back   = {low, low} << ptr;
        onehot = back[2*N-1:N];
        any    = |req;
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among N requesters with round-robin grant,
// per-device chip selects, CS setup/gap timing and a done timeout.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic           err,
    output logic           busy,
    output logic [N-1:0]   cs_n,
    output logic           m_start,
    output logic [7:0]     m_data,
    input  logic           m_done
);

    localparam int MAXC = max3(CS_SETUP, GAP_CYC, TIMEOUT);
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int PW   = (N > 1) ? $clog2(N) : 1;

    spi_state_e    state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] pidx;
    logic [PW-1:0] nptr;
    logic [N-1:0]  pick;
    logic          any;
    logic [7:0]    pdata;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick),
        .any    (any)
    );

    // index and byte of the picked requester, next pointer after owner
    always_comb begin
        pidx  = '0;
        pdata = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                pidx  = PW'(i);
                pdata = data[8*i +: 8];
            end
        end
        nptr = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end

    // transaction FSM: grant, CS setup, wait for done or timeout, gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            gidx    <= '0;
            grant   <= '0;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            cs_n    <= '1;
            m_start <= 1'b0;
            m_data  <= '0;
        end else begin
            ack     <= '0;
            err     <= 1'b0;
            m_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        grant  <= pick;
                        cs_n   <= ~pick;
                        m_data <= pdata;
                        gidx   <= pidx;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        m_start <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_BUSY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BUSY: begin
                    if (m_done) begin
                        ack   <= grant;
                        grant <= '0;
                        cs_n  <= '1;
                        ptr   <= nptr;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        cs_n  <= '1;
                        ptr   <= nptr;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    grant <= '0;
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
